gaussian_blurrer_multi: RTL and testbench

Parametrised Gaussian blur engine that reads a packed multi-channel image from the frame SRAM and writes a blurred copy to a second region. It has a run-time selectable 3x3 or 5x5 binomial kernel, edge replication, and a configurable memory read latency. It sits between the frame store and the corner/line-detection stages of the Rectilinearizer. It replaces the fixed-size blurrer with one generalised in image size, channel count/width, kernel size and source/destination placement.

---
 rtl/gaussian_blurrer_multi.sv | 252 +++++++++++++++++++++++++
 tb/tb_gaussian_blurrer_multi.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_blurrer_multi.sv
// Separable binomial blur (3x3 or 5x5) over a packed multi-channel frame.
// Taps are clamped to the image, so the border replicates edge pixels.
module gaussian_blurrer_multi #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter int CH_W   = 10,
  parameter int NUM_CH = 3,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = CH_W + 8;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW:0] RND3 = (AW+1)'(8);
  localparam logic [AW:0] RND5 = (AW+1)'(128);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, WRITE, DONE
  } state_t;

  state_t state, state_n;

  logic              mode_r;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [2:0]        ty, tx, ty_n, tx_n;
  logic [2:0]        kmax;
  logic              k5_n, load;
  logic [ADDR_W-1:0] base_n, addr_n;
  logic [DW-1:0]     drain_cnt;
  logic              last_tap, last_px;
  logic              tap_v, al_v;
  logic [5:0]        tap_w, al_w;
  logic [AW-1:0]     acc [NUM_CH];
  logic [AW-1:0]     sum [NUM_CH];
  logic [AW:0]       rnd [NUM_CH];
  logic [DATA_W-1:0] wdata_n;
  logic              unused_hi;

  assign unused_hi = ^read_data;

  function automatic logic [2:0] w1(
    input logic       k5,
    input logic [2:0] i
  );
    logic [2:0] w;
    w = 3'd1;
    if (!k5 && i == 3'd1) w = 3'd2;
    if (k5 && (i == 3'd1 || i == 3'd3)) w = 3'd4;
    if (k5 && i == 3'd2) w = 3'd6;
    return w;
  endfunction

  function automatic int clampi(
    input int v,
    input int hi
  );
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  assign kmax     = mode_r ? 3'd4 : 3'd2;
  assign last_tap = (ty == kmax) && (tx == kmax);
  assign last_px  = (int'(x) == IMG_W - 1) &&
                    (int'(y) == IMG_H - 1);
  assign busy     = (state == READ) ||
                    (state == DRAIN) ||
                    (state == WRITE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = READ;
      READ:  if (last_tap)
               state_n = (RD_LAT == 0) ? WRITE : DRAIN;
      DRAIN: if (int'(drain_cnt) >= RD_LAT - 1)
               state_n = WRITE;
      WRITE: state_n = last_px ? DONE : READ;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Coordinates of the tap that read_addr will carry next cycle
  always_comb begin
    k5_n   = mode_r;
    base_n = src_r;
    x_n    = x;
    y_n    = y;
    ty_n   = ty;
    tx_n   = tx;
    load   = 1'b0;
    unique case (1'b1)
      (state == IDLE) && start: begin
        k5_n   = mode;
        base_n = src_base;
        x_n    = '0;
        y_n    = '0;
        ty_n   = '0;
        tx_n   = '0;
        load   = 1'b1;
      end
      (state == READ) && !last_tap: begin
        load = 1'b1;
        if (tx == kmax) begin
          tx_n = '0;
          ty_n = ty + 3'd1;
        end else begin
          tx_n = tx + 3'd1;
        end
      end
      (state == WRITE) && !last_px: begin
        load = 1'b1;
        ty_n = '0;
        tx_n = '0;
        if (int'(x) == IMG_W - 1) begin
          x_n = '0;
          y_n = y + YW'(1);
        end else begin
          x_n = x + XW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    int half, cx, cy;
    half = k5_n ? 2 : 1;
    cx = clampi(int'(x_n) + int'(tx_n) - half, IMG_W - 1);
    cy = clampi(int'(y_n) + int'(ty_n) - half, IMG_H - 1);
    addr_n = base_n + ADDR_W'(cy * IMG_W + cx);
  end

  assign tap_v = (state == READ);
  assign tap_w = {3'b0, w1(mode_r, ty)} *
                 {3'b0, w1(mode_r, tx)};

  // Weight travels with its address so it meets the returning word
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign al_v = tap_v;
      assign al_w = tap_w;
    end else begin : g_lat
      logic       v_d [RD_LAT];
      logic [5:0] w_d [RD_LAT];
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < RD_LAT; i++) begin
            v_d[i] <= 1'b0;
            w_d[i] <= '0;
          end
        end else begin
          v_d[0] <= tap_v;
          w_d[0] <= tap_w;
          for (int i = 1; i < RD_LAT; i++) begin
            v_d[i] <= v_d[i-1];
            w_d[i] <= w_d[i-1];
          end
        end
      end
      assign al_v = v_d[RD_LAT-1];
      assign al_w = w_d[RD_LAT-1];
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum[c] = acc[c];
      if (al_v)
        sum[c] = acc[c] + AW'(al_w) *
                 AW'(read_data[c*CH_W +: CH_W]);
    end
  end

  always_comb begin
    wdata_n = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rnd[c] = {1'b0, sum[c]} + (mode_r ? RND5 : RND3);
      wdata_n[c*CH_W +: CH_W] =
        CH_W'(mode_r ? rnd[c] >> 8 : rnd[c] >> 4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_r     <= 1'b0;
      src_r      <= '0;
      dst_r      <= '0;
      x          <= '0;
      y          <= '0;
      ty         <= '0;
      tx         <= '0;
      read_addr  <= '0;
      write_addr <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
      drain_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      write_en <= 1'b0;
      if (state == IDLE && start) begin
        mode_r <= mode;
        src_r  <= src_base;
        dst_r  <= dst_base;
      end
      if (load) begin
        read_addr <= addr_n;
        x  <= x_n;
        y  <= y_n;
        ty <= ty_n;
        tx <= tx_n;
      end
      drain_cnt <= (state == DRAIN && state_n == DRAIN) ?
                   drain_cnt + DW'(1) : '0;
      if (state_n == WRITE) begin
        write_en   <= 1'b1;
        write_addr <= dst_r +
                      ADDR_W'(int'(y) * IMG_W + int'(x));
        write_data <= wdata_n;
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) acc[c] <= sum[c];
      end
    end
  end

endmodule

// File: tb/tb_gaussian_blurrer_multi.sv
// Scoreboard bench: three blurrers (RD_LAT 2/1/0) on 10x1 and 3x3
// frames, directed images with hand-derived expected pixels.
module tb_gaussian_blurrer_multi;
  typedef struct {
    logic [18:0] a;
    logic [35:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [18:0] src_base = '0;
  logic [18:0] dst_base = '0;
  logic        st [3];
  logic [18:0] ra0, ra1, ra2, wa0, wa1, wa2;
  logic [35:0] rd0, rd1, rd2, wd0, wd1, wd2;
  logic        we0, we1, we2, bz0, bz1, bz2, dn0, dn1, dn2;
  logic [18:0] ra [3];
  logic [18:0] wa [3];
  logic [35:0] wd [3];
  logic        we [3];
  logic        bz [3];
  logic        dn [3];
  logic [35:0] mem [3][128];
  logic [35:0] pa [2];
  logic [35:0] pb;
  wr_t         exp_q [3][$];
  int          nwr [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  int imp  [10] = '{0, 0, 0, 0, 0, 512, 0, 0, 0, 0};
  int imp3 [10] = '{0, 0, 0, 0, 128, 256, 128, 0, 0, 0};
  int imp5 [10] = '{0, 0, 0, 32, 128, 192, 128, 32, 0, 0};
  int edg  [10] = '{512, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int edg3 [10] = '{384, 128, 0, 0, 0, 0, 0, 0, 0, 0};
  int full [10] = '{default: 1023};
  int cen  [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
  int cen3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  gaussian_blurrer_multi #(
    .IMG_W(10), .IMG_H(1), .RD_LAT(2)
  ) u_a (
    .clk(clk), .reset(reset), .start(st[0]),
    .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .busy(bz0), .done(dn0),
    .read_addr(ra0), .read_data(rd0),
    .write_addr(wa0), .write_data(wd0),
    .write_en(we0)
  );

  gaussian_blurrer_multi #(
    .IMG_W(3), .IMG_H(3), .RD_LAT(1)
  ) u_b (
    .clk(clk), .reset(reset), .start(st[1]),
    .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .busy(bz1), .done(dn1),
    .read_addr(ra1), .read_data(rd1),
    .write_addr(wa1), .write_data(wd1),
    .write_en(we1)
  );

  gaussian_blurrer_multi #(
    .IMG_W(10), .IMG_H(1), .RD_LAT(0)
  ) u_c (
    .clk(clk), .reset(reset), .start(st[2]),
    .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .busy(bz2), .done(dn2),
    .read_addr(ra2), .read_data(rd2),
    .write_addr(wa2), .write_data(wd2),
    .write_en(we2)
  );

  always @(posedge clk) begin
    pa[0] <= mem[0][ra0[6:0]];
    pa[1] <= pa[0];
    pb    <= mem[1][ra1[6:0]];
  end

  always_comb begin
    rd0 = pa[1];
    rd1 = pb;
    rd2 = mem[2][ra2[6:0]];
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    wa[0] = wa0; wa[1] = wa1; wa[2] = wa2;
    wd[0] = wd0; wd[1] = wd1; wd[2] = wd2;
    we[0] = we0; we[1] = we1; we[2] = we2;
    bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
    dn[0] = dn0; dn[1] = dn1; dn[2] = dn2;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [35:0] pk(input int c0, input int c1,
                                     input int c2);
    return {6'b0, 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  always @(negedge clk) begin
    wr_t e;
    for (int i = 0; i < 3; i++) begin
      if (reset && we[i]) begin
        nwr[i]++;
        if (exp_q[i].size() == 0) begin
          chk($sformatf("unexpected_write%0d", i), 1, 0);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("waddr%0d", i), wa[i], e.a);
          chk($sformatf("wdata%0d", i), wd[i], e.d);
        end
      end
    end
  end

  task automatic load(input int i, input int n,
                      input int v[10], input bit all);
    for (int k = 0; k < 128; k++) mem[i][k] = '0;
    for (int k = 0; k < n; k++)
      mem[i][k] = all ? pk(v[k], v[k], v[k]) : pk(0, v[k], 0);
  endtask

  task automatic exp_row(input int i, input int dst, input int n,
                         input int v[10], input bit all);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      e.a = 19'(dst + k);
      e.d = all ? pk(v[k], v[k], v[k]) : pk(0, v[k], 0);
      exp_q[i].push_back(e);
    end
  endtask

  task automatic run(input int i, input bit md, input int src,
                     input int dst, input int exp_done,
                     input int npx, input bit glitch);
    int cyc, rbad, w0;
    bit seen;
    w0 = nwr[i];
    @(negedge clk);
    mode = md;
    src_base = 19'(src);
    dst_base = 19'(dst);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    cyc = 1;
    seen = 0;
    rbad = 0;
    chk("busy_cycle1", bz[i], 1);
    while (!seen && cyc < 2000) begin
      if (dn[i]) begin
        seen = 1;
      end else begin
        if (bz[i] && (int'(ra[i]) < src ||
                      int'(ra[i]) >= src + npx))
          rbad++;
        if (glitch && cyc == 30) begin
          st[i] = 1'b1;
          mode = ~md;
          src_base = 19'(src + 7);
          dst_base = 19'(dst + 3);
        end else if (glitch && cyc == 31) begin
          st[i] = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_cycle", seen ? cyc : -1, exp_done);
    chk("busy_at_done", bz[i], 0);
    chk("read_range", rbad, 0);
    chk("write_count", nwr[i] - w0, npx);
    chk("queue_left", exp_q[i].size(), 0);
    exp_q[i].delete();
    mode = md;
    src_base = 19'(src);
    dst_base = 19'(dst);
  endtask

  initial begin
    int w0, cyc;
    st = '{default: 1'b0};
    nwr = '{default: 0};
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_we", we[0], 0);
    chk("rst_raddr", ra[0], 0);
    chk("rst_waddr", wa[0], 0);
    chk("rst_wdata", wd[0], 0);

    load(0, 10, imp, 0);
    exp_row(0, 100, 10, imp3, 0);
    run(0, 0, 0, 100, 121, 10, 1);

    exp_row(0, 100, 10, imp5, 0);
    run(0, 1, 0, 100, 281, 10, 0);

    load(0, 10, edg, 0);
    exp_row(0, 100, 10, edg3, 0);
    run(0, 0, 0, 100, 121, 10, 0);

    load(0, 10, full, 1);
    exp_row(0, 100, 10, full, 1);
    run(0, 1, 0, 100, 281, 10, 0);

    load(0, 10, imp, 0);
    exp_row(0, 100, 10, imp3, 0);
    @(negedge clk);
    mode = 1'b0;
    src_base = '0;
    dst_base = 19'd100;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_we", we[0], 0);
    chk("midrst_busy", bz[0], 0);
    exp_q[0].delete();
    w0 = nwr[0];
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_nowrite", nwr[0] - w0, 0);

    exp_row(0, 100, 10, imp3, 0);
    run(0, 0, 0, 100, 121, 10, 0);

    load(1, 9, cen, 1);
    exp_row(1, 50, 9, cen3, 1);
    run(1, 0, 0, 50, 100, 9, 0);

    load(2, 10, imp, 0);
    exp_row(2, 100, 10, imp3, 0);
    run(2, 0, 0, 100, 101, 10, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
